inst_rom_loader: RTL and testbench

//   Instruction-memory responder for the core fetch port: returns inst_o for inst_addr_i in the same cycle (combinational read).

---
 rtl/inst_rom_loader.sv | 221 ++++++++++++++++++++++
 tb/tb_inst_rom_loader.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_rom_loader.sv
// inst_rom_loader
//   Instruction memory for the core fetch port plus a byte-serial boot loader.
//   The core reads one 32-bit word per cycle, combinationally. The core is held
//   in reset while a program is streamed in over a valid/ready byte interface.
//   Bytes arrive little-endian within each word.
//
//   Optional feature, selected by the macro LOAD_CHECKSUM_EN:
//     defined   - after the last data word one extra word is received. It is not
//                 stored. It must equal the XOR of all data words. On a mismatch
//                 err_o is set and stays set until the next accepted
//                 load_start_i, and the core stays in reset.
//     undefined - there is no checksum word and err_o is tied to 0.
//
// Ports
//   clk, rst_n    clock, asynchronous active-low reset
//   load_start_i  pulse that starts a load (accepted in IDLE/RUN only)
//   load_len_i    number of words to load (clamped to DEPTH), sampled with start
//   byte_valid_i  byte_data_i is valid
//   byte_data_i   program byte
//   byte_ready_o  loader takes a byte this cycle (RECV only)
//   inst_addr_i   byte address from core fetch; bits [1:0] are ignored
//   inst_o        instruction to core; NOP while the core is held or out of range
//   core_rst_n_o  registered active-low reset to the core, high only in RUN
//   busy_o        load in progress (RECV/WRITE)
//   done_o        single-cycle pulse when a load completes
//   err_o         sticky checksum error
module inst_rom_loader #(
    parameter int          DEPTH    = 4096,
    parameter int          AW       = $clog2(DEPTH),
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load_start_i,
    input  logic [AW:0]   load_len_i,
    input  logic          byte_valid_i,
    input  logic [7:0]    byte_data_i,
    output logic          byte_ready_o,
    input  logic [31:0]   inst_addr_i,
    output logic [31:0]   inst_o,
    output logic          core_rst_n_o,
    output logic          busy_o,
    output logic          done_o,
    output logic          err_o
);

    typedef enum logic [1:0] {IDLE, RECV, WRITE, RUN} state_t;

    localparam logic [AW:0] DEPTH_L   = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE_L     = (AW+1)'(1);
    localparam logic [29:0] DEPTH_IDX = 30'(DEPTH);

    state_t      state_q, state_nxt;
    logic [1:0]  bcnt_q;
    logic [AW:0] wcnt_q;
    logic [AW:0] len_q;
    logic [31:0] word_q;
    logic        core_rst_n_q;

    logic        start_acc;
    logic        byte_acc;
    logic [AW:0] len_clamped;
    logic [AW:0] wcnt_inc;
    logic        last_word;

    logic [31:0] mem [DEPTH];

`ifdef LOAD_CHECKSUM_EN
    logic [31:0] xor_q;
    logic        ck_phase_q;
    logic        ck_enter;
    logic        ck_fail;
    logic        err_q;
    logic [31:0] ck_word;

    // The 4th checksum byte is compared on arrival, so the full word is
    // assembled from the incoming byte and the three bytes already held.
    assign ck_word = {byte_data_i, word_q[23:0]};
`endif

    assign len_clamped = (load_len_i > DEPTH_L) ? DEPTH_L : load_len_i;
    assign wcnt_inc    = wcnt_q + ONE_L;
    assign last_word   = (wcnt_inc == len_q);

    // Next-state and outputs
    always_comb begin
        state_nxt    = state_q;
        start_acc    = 1'b0;
        byte_acc     = 1'b0;
        byte_ready_o = 1'b0;
        busy_o       = 1'b0;
        done_o       = 1'b0;
`ifdef LOAD_CHECKSUM_EN
        ck_enter     = 1'b0;
        ck_fail      = 1'b0;
`endif
        case (state_q)
            IDLE, RUN: begin
                if (load_start_i) begin
                    start_acc = 1'b1;
                    if (len_clamped == '0) begin
                        state_nxt = RUN;
                        done_o    = 1'b1;
                    end else begin
                        state_nxt = RECV;
                    end
                end
            end
            RECV: begin
                byte_ready_o = 1'b1;
                busy_o       = 1'b1;
                byte_acc     = byte_valid_i;
                if (byte_valid_i && bcnt_q == 2'd3) begin
`ifdef LOAD_CHECKSUM_EN
                    if (ck_phase_q) begin
                        if (ck_word == xor_q) begin
                            state_nxt = RUN;
                            done_o    = 1'b1;
                        end else begin
                            state_nxt = IDLE;
                            ck_fail   = 1'b1;
                        end
                    end else begin
                        state_nxt = WRITE;
                    end
`else
                    state_nxt = WRITE;
`endif
                end
            end
            WRITE: begin
                busy_o = 1'b1;
                if (last_word) begin
`ifdef LOAD_CHECKSUM_EN
                    state_nxt = RECV;
                    ck_enter  = 1'b1;
`else
                    state_nxt = RUN;
                    done_o    = 1'b1;
`endif
                end else begin
                    state_nxt = RECV;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            bcnt_q       <= '0;
            wcnt_q       <= '0;
            len_q        <= '0;
            word_q       <= '0;
            core_rst_n_q <= 1'b0;
        end else begin
            state_q      <= state_nxt;
            // Core leaves reset only together with the move into RUN, and is
            // pulled back into reset one cycle after a load starts.
            core_rst_n_q <= (state_nxt == RUN);
            if (start_acc) begin
                bcnt_q <= '0;
                wcnt_q <= '0;
                len_q  <= len_clamped;
                word_q <= '0;
            end else begin
                if (byte_acc) begin
                    word_q[8*bcnt_q +: 8] <= byte_data_i;
                    bcnt_q                <= bcnt_q + 2'd1;
                end
                if (state_q == WRITE)
                    wcnt_q <= wcnt_inc;
            end
        end
    end

`ifdef LOAD_CHECKSUM_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xor_q      <= '0;
            ck_phase_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            if (start_acc) begin
                xor_q      <= '0;
                ck_phase_q <= 1'b0;
                err_q      <= 1'b0;
            end else begin
                if (state_q == WRITE)
                    xor_q <= xor_q ^ word_q;
                if (ck_enter)
                    ck_phase_q <= 1'b1;
                if (ck_fail)
                    err_q <= 1'b1;
            end
        end
    end

    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

    // Storage is not reset. Words written before a reset survive it.
    always_ff @(posedge clk) begin
        if (state_q == WRITE)
            mem[wcnt_q[AW-1:0]] <= word_q;
    end

    // Fetch path: word index from the byte address, zero-cycle latency
    logic [29:0] rd_idx;
    logic        unused_addr_lsb;

    assign rd_idx          = inst_addr_i[31:2];
    assign unused_addr_lsb = ^inst_addr_i[1:0];
    assign core_rst_n_o    = core_rst_n_q;
    assign inst_o          = (!core_rst_n_q || rd_idx >= DEPTH_IDX) ? NOP_INST
                                                                    : mem[rd_idx[AW-1:0]];

endmodule

// File: tb/tb_inst_rom_loader.sv
module tb_inst_rom_loader;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        load_start_i;
    logic [12:0] load_len_i;
    logic        byte_valid_i;
    logic [7:0]  byte_data_i;
    logic        byte_ready_o;
    logic [31:0] inst_addr_i;
    logic [31:0] inst_o;
    logic        core_rst_n_o;
    logic        busy_o;
    logic        done_o;
    logic        err_o;

    int vectors = 0;
    int miscompares = 0;
    int done_cnt = 0;
    int wr_cycles = 0;

    inst_rom_loader dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .load_start_i (load_start_i),
        .load_len_i   (load_len_i),
        .byte_valid_i (byte_valid_i),
        .byte_data_i  (byte_data_i),
        .byte_ready_o (byte_ready_o),
        .inst_addr_i  (inst_addr_i),
        .inst_o       (inst_o),
        .core_rst_n_o (core_rst_n_o),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .err_o        (err_o)
    );

    always #5 clk = ~clk;

    // done pulses and WRITE cycles (busy with ready low), sampled at the edge
    always @(posedge clk) begin
        if (done_o) done_cnt <= done_cnt + 1;
        if (busy_o && !byte_ready_o) wr_cycles <= wr_cycles + 1;
    end

    function automatic logic [31:0] pat(input int i);
        logic [15:0] h;
        h = 16'(i);
        return {h, ~h};
    endfunction

    task automatic start_load(input logic [12:0] len);
        @(negedge clk);
        load_start_i = 1'b1;
        load_len_i   = len;
        @(negedge clk);
        load_start_i = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gap, output bit ok);
        ok = 1'b0;
        @(negedge clk);
        if (gap) begin
            byte_valid_i = 1'b0;
            @(negedge clk);
        end
        byte_valid_i = 1'b1;
        byte_data_i  = b;
        for (int n = 0; n < 50; n++) begin
            #1;
            if (byte_ready_o) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic send_word(input logic [31:0] w, input bit gap, inout bit ok);
        bit bok;
        for (int k = 0; k < 4; k++) begin
            send_byte(w[8*k +: 8], gap, bok);
            ok = ok & bok;
        end
    endtask

    task automatic load_words(input logic [31:0] w[$], input logic [12:0] len,
                              input bit gap, input bit bad_ck, output bit ok);
        logic [31:0] x;
        ok = 1'b1;
        x  = '0;
        start_load(len);
        foreach (w[i]) begin
            send_word(w[i], gap, ok);
            x = x ^ w[i];
        end
`ifdef LOAD_CHECKSUM_EN
        send_word(bad_ck ? 32'h0 : x, gap, ok);
`else
        if (bad_ck) x = '0;
`endif
        @(negedge clk);
        byte_valid_i = 1'b0;
    endtask

    task automatic wait_done(input int d0, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 40; n++) begin
            if (done_cnt > d0) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        inst_addr_i = 32'h0;
        #1;
        vectors++; if (inst_o !== NOP) begin miscompares++; $display("FAIL rst_inst0: got %h exp %h", inst_o, NOP); end
        inst_addr_i = 32'h8;
        #1;
        vectors++; if (inst_o !== NOP) begin miscompares++; $display("FAIL rst_inst8: got %h exp %h", inst_o, NOP); end
        vectors++; if ({core_rst_n_o, byte_ready_o, busy_o, done_o, err_o} !== 5'b0) begin
            miscompares++; $display("FAIL rst_flags: got %b exp 00000", {core_rst_n_o, byte_ready_o, busy_o, done_o, err_o});
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        vectors++; if ({core_rst_n_o, busy_o, byte_ready_o} !== 3'b0) begin
            miscompares++; $display("FAIL idle_flags: got %b exp 000", {core_rst_n_o, busy_o, byte_ready_o});
        end
    endtask

    task automatic check_prog2(input string tag);
        inst_addr_i = 32'h0; #1;
        vectors++; if (inst_o !== 32'h0050_0093) begin miscompares++; $display("FAIL %s_addr0: got %h exp 00500093", tag, inst_o); end
        inst_addr_i = 32'h4; #1;
        vectors++; if (inst_o !== 32'h00A0_0113) begin miscompares++; $display("FAIL %s_addr4: got %h exp 00a00113", tag, inst_o); end
        inst_addr_i = 32'h2; #1;
        vectors++; if (inst_o !== 32'h0050_0093) begin miscompares++; $display("FAIL %s_addr2: got %h exp 00500093", tag, inst_o); end
    endtask

    task automatic test_load;
        logic [31:0] q[$];
        bit ok, dok;
        int d0;
        q  = '{32'h0050_0093, 32'h00A0_0113};
        d0 = done_cnt;
        load_words(q, 13'd2, 1'b0, 1'b0, ok);
        wait_done(d0, dok);
        vectors++; if (!(ok && dok)) begin miscompares++; $display("FAIL load_done: got bytes_ok=%0d done_seen=%0d exp 1 1", ok, dok); end
        repeat (2) @(negedge clk);
        vectors++; if (done_cnt - d0 !== 1) begin miscompares++; $display("FAIL load_pulse: got %0d exp 1", done_cnt - d0); end
        vectors++; if ({core_rst_n_o, busy_o} !== 2'b10) begin miscompares++; $display("FAIL load_run: got %b exp 10", {core_rst_n_o, busy_o}); end
        check_prog2("load");
    endtask

    task automatic test_gap;
        logic [31:0] q[$];
        bit ok, dok;
        int d0, w0;
        q  = '{32'h0050_0093, 32'h00A0_0113};
        d0 = done_cnt;
        w0 = wr_cycles;
        load_words(q, 13'd2, 1'b1, 1'b0, ok);
        wait_done(d0, dok);
        repeat (2) @(negedge clk);
        vectors++; if (!(ok && dok)) begin miscompares++; $display("FAIL gap_done: got bytes_ok=%0d done_seen=%0d exp 1 1", ok, dok); end
        vectors++; if (wr_cycles - w0 !== 2) begin miscompares++; $display("FAIL gap_write_ready_low: got %0d exp 2", wr_cycles - w0); end
        vectors++; if (done_cnt - d0 !== 1) begin miscompares++; $display("FAIL gap_pulse: got %0d exp 1", done_cnt - d0); end
        check_prog2("gap");
    endtask

    task automatic test_oob;
        inst_addr_i = 32'h0000_4000; #1;
        vectors++; if (inst_o !== NOP) begin miscompares++; $display("FAIL oob_4000: got %h exp %h", inst_o, NOP); end
        inst_addr_i = 32'hFFFF_FFFC; #1;
        vectors++; if (inst_o !== NOP) begin miscompares++; $display("FAIL oob_top: got %h exp %h", inst_o, NOP); end
    endtask

    task automatic test_midload_abort;
        logic [31:0] q[$];
        bit ok, dok;
        int d0, w0;
        start_load(13'd2);
        #1;
        vectors++; if ({core_rst_n_o, busy_o} !== 2'b01) begin miscompares++; $display("FAIL mid_held: got %b exp 01", {core_rst_n_o, busy_o}); end
        ok = 1'b1;
        send_byte(8'h11, 1'b0, ok);
        send_byte(8'h22, 1'b0, ok);
        @(negedge clk);
        byte_valid_i = 1'b0;
        load_start_i = 1'b1;
        load_len_i   = 13'd1;
        @(negedge clk);
        load_start_i = 1'b0;
        d0 = done_cnt;
        w0 = wr_cycles;
        send_byte(8'h33, 1'b0, ok);
        send_byte(8'h44, 1'b0, ok);
        @(negedge clk);
        byte_valid_i = 1'b0;
        repeat (2) @(negedge clk);
        // start was ignored: the 4th byte completes word 0 and the load continues
        vectors++; if (wr_cycles - w0 !== 1) begin miscompares++; $display("FAIL mid_start_ignored: got writes=%0d exp 1", wr_cycles - w0); end
        vectors++; if ({busy_o, core_rst_n_o, done_cnt - d0 == 0} !== 3'b101) begin
            miscompares++; $display("FAIL mid_still_loading: got %b exp 101", {busy_o, core_rst_n_o, done_cnt - d0 == 0});
        end
        rst_n = 1'b0;
        inst_addr_i = 32'h0;
        #1;
        vectors++; if ({busy_o, core_rst_n_o, byte_ready_o} !== 3'b000 || inst_o !== NOP) begin
            miscompares++; $display("FAIL mid_reset: got flags=%b inst=%h exp 000 %h", {busy_o, core_rst_n_o, byte_ready_o}, inst_o, NOP);
        end
        @(negedge clk);
        rst_n = 1'b1;
        q  = '{32'h0000_0537};
        d0 = done_cnt;
        load_words(q, 13'd1, 1'b0, 1'b0, ok);
        wait_done(d0, dok);
        vectors++; if (!(ok && dok)) begin miscompares++; $display("FAIL reload_done: got bytes_ok=%0d done_seen=%0d exp 1 1", ok, dok); end
        inst_addr_i = 32'h0; #1;
        vectors++; if (inst_o !== 32'h0000_0537) begin miscompares++; $display("FAIL reload_addr0: got %h exp 00000537", inst_o); end
        inst_addr_i = 32'h4; #1;
        vectors++; if (inst_o !== 32'h00A0_0113) begin miscompares++; $display("FAIL reload_retained4: got %h exp 00a00113", inst_o); end
    endtask

    task automatic test_len_zero;
        int d0;
        d0 = done_cnt;
        start_load(13'd0);
        inst_addr_i = 32'h0;
        #1;
        vectors++; if (done_cnt - d0 !== 1) begin miscompares++; $display("FAIL len0_pulse: got %0d exp 1", done_cnt - d0); end
        vectors++; if ({core_rst_n_o, busy_o} !== 2'b10 || inst_o !== 32'h0000_0537) begin
            miscompares++; $display("FAIL len0_run: got flags=%b inst=%h exp 10 00000537", {core_rst_n_o, busy_o}, inst_o);
        end
    endtask

    task automatic test_clamp;
        logic [31:0] q[$];
        bit ok, dok;
        int d0;
        for (int i = 0; i < 4096; i++) q.push_back(pat(i));
        d0 = done_cnt;
        load_words(q, 13'd5000, 1'b0, 1'b0, ok);
        wait_done(d0, dok);
        vectors++; if (!(ok && dok)) begin miscompares++; $display("FAIL clamp_done: got bytes_ok=%0d done_seen=%0d exp 1 1", ok, dok); end
        inst_addr_i = 32'h0000_3FFC; #1;
        vectors++; if (inst_o !== pat(4095)) begin miscompares++; $display("FAIL clamp_last: got %h exp %h", inst_o, pat(4095)); end
        inst_addr_i = 32'h0000_0000; #1;
        vectors++; if (inst_o !== pat(0)) begin miscompares++; $display("FAIL clamp_first: got %h exp %h", inst_o, pat(0)); end
        inst_addr_i = 32'h0000_4000; #1;
        vectors++; if (inst_o !== NOP) begin miscompares++; $display("FAIL clamp_oob: got %h exp %h", inst_o, NOP); end
    endtask

`ifdef LOAD_CHECKSUM_EN
    task automatic test_checksum;
        logic [31:0] q[$];
        bit ok, dok;
        int d0;
        q  = '{32'h0050_0093, 32'h00A0_0113};
        d0 = done_cnt;
        load_words(q, 13'd2, 1'b0, 1'b0, ok);
        wait_done(d0, dok);
        #1;
        vectors++; if (!(ok && dok) || core_rst_n_o !== 1'b1 || err_o !== 1'b0) begin
            miscompares++; $display("FAIL ck_good: got done=%0d core=%b err=%b exp 1 1 0", dok, core_rst_n_o, err_o);
        end
        d0 = done_cnt;
        load_words(q, 13'd2, 1'b0, 1'b1, ok);
        repeat (3) @(negedge clk);
        vectors++; if ({err_o, core_rst_n_o, busy_o} !== 3'b100 || done_cnt != d0) begin
            miscompares++; $display("FAIL ck_bad: got err/core/busy=%b dones=%0d exp 100 0", {err_o, core_rst_n_o, busy_o}, done_cnt - d0);
        end
        start_load(13'd0);
        #1;
        vectors++; if ({err_o, core_rst_n_o} !== 2'b01) begin miscompares++; $display("FAIL ck_err_clear: got %b exp 01", {err_o, core_rst_n_o}); end
    endtask
`else
    task automatic test_err_tied;
        #1;
        vectors++; if (err_o !== 1'b0) begin miscompares++; $display("FAIL err_tied: got %b exp 0", err_o); end
    endtask
`endif

    initial begin
        rst_n        = 1'b0;
        load_start_i = 1'b0;
        load_len_i   = '0;
        byte_valid_i = 1'b0;
        byte_data_i  = '0;
        inst_addr_i  = '0;
        repeat (2) @(negedge clk);
        test_reset();
        test_load();
        test_gap();
        test_oob();
        test_midload_abort();
        test_len_zero();
        test_clamp();
`ifdef LOAD_CHECKSUM_EN
        test_checksum();
`else
        test_err_tied();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
